// File: rtl/id_ex_skid.sv
// id_ex_skid: ID/EX pipeline register with valid/ready handshake and a
// two-entry skid buffer (main entry M drives ex_*, skid entry S absorbs one
// extra payload so id_ready can be a register).
// Optional feature: define ID_EX_PERF_EN to add perf_bubble_cnt.
module id_ex_skid #(
  parameter int unsigned          ALUOP_W    = 8,
  parameter int unsigned          ALUSEL_W   = 3,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          RADDR_W    = 5,
  parameter logic [ALUOP_W-1:0]   NOP_ALUOP  = '0,
  parameter logic [ALUSEL_W-1:0]  NOP_ALUSEL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [RADDR_W-1:0]  id_waddr,
  input  logic                id_we,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [RADDR_W-1:0]  ex_waddr,
  output logic                ex_we
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         perf_bubble_cnt
`endif
);

  localparam int unsigned PW = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 1;

  localparam logic [PW-1:0] NOP_PAYLOAD = {NOP_ALUOP, NOP_ALUSEL,
                                           {DATA_W{1'b0}}, {DATA_W{1'b0}},
                                           {RADDR_W{1'b0}}, 1'b0};

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;
  logic          id_ready_q, id_ready_d;
  logic [PW-1:0] id_payload;
  logic          acc, pop;

  assign id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_we};

  assign ex_valid = (state_q != ST_EMPTY);
  assign id_ready = id_ready_q;
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_we} = m_q;

  assign acc = id_valid & id_ready_q;
  assign pop = ex_valid & ex_ready;

  // Next-state: occupancy transitions, payload moves, flush override.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          m_d     = id_payload;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          m_d = id_payload;
        end else if (acc) begin
          state_d = ST_FULL;
          s_d     = id_payload;
        end else if (pop) begin
          state_d = ST_EMPTY;
          m_d     = NOP_PAYLOAD;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          m_d     = s_q;
          s_d     = NOP_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        m_d     = NOP_PAYLOAD;
        s_d     = NOP_PAYLOAD;
      end
    endcase
    // Flush discards both entries and any payload accepted this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = NOP_PAYLOAD;
      s_d     = NOP_PAYLOAD;
    end
    // id_ready is precomputed so it equals ~S-valid during the next cycle.
    id_ready_d = (state_d != ST_FULL);
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      m_q        <= NOP_PAYLOAD;
      s_q        <= NOP_PAYLOAD;
      id_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      id_ready_q <= id_ready_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles where execute could consume but nothing is offered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (ex_ready && !ex_valid && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = perf_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Testbench for id_ex_skid: directed scenarios followed by random traffic,
// all checked against a queue-based model of the in-flight instructions.
module tb_id_ex_skid;

  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned PW       = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 1;
  localparam logic [ALUOP_W-1:0]  T_NOP_ALUOP  = 8'hA5;
  localparam logic [ALUSEL_W-1:0] T_NOP_ALUSEL = 3'h5;
  localparam logic [PW-1:0] NOP_PL = {T_NOP_ALUOP, T_NOP_ALUSEL, 70'd0};

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic                id_valid = 1'b0;
  logic                id_ready;
  logic [PW-1:0]       id_pl = '0;
  logic [ALUOP_W-1:0]  id_aluop;
  logic [ALUSEL_W-1:0] id_alusel;
  logic [DATA_W-1:0]   id_reg1, id_reg2;
  logic [RADDR_W-1:0]  id_waddr;
  logic                id_we;
  logic                ex_valid;
  logic                ex_ready = 1'b0;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_reg1, ex_reg2;
  logic [RADDR_W-1:0]  ex_waddr;
  logic                ex_we;
`ifdef ID_EX_PERF_EN
  logic [31:0]         perf_bubble_cnt;
`endif

  assign {id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_we} = id_pl;

  id_ex_skid #(
    .ALUOP_W    (ALUOP_W),
    .ALUSEL_W   (ALUSEL_W),
    .DATA_W     (DATA_W),
    .RADDR_W    (RADDR_W),
    .NOP_ALUOP  (T_NOP_ALUOP),
    .NOP_ALUSEL (T_NOP_ALUSEL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_aluop  (id_aluop),
    .id_alusel (id_alusel),
    .id_reg1   (id_reg1),
    .id_reg2   (id_reg2),
    .id_waddr  (id_waddr),
    .id_we     (id_we),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_aluop  (ex_aluop),
    .ex_alusel (ex_alusel),
    .ex_reg1   (ex_reg1),
    .ex_reg2   (ex_reg2),
    .ex_waddr  (ex_waddr),
    .ex_we     (ex_we)
`ifdef ID_EX_PERF_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: ordered list of instructions held by the block.
  logic [PW-1:0] mq[$];
  logic [31:0]   m_bubbles = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [PW-1:0] obs_pl;
    logic [PW-1:0] exp_pl;
    obs_pl = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_we};
    exp_pl = (mq.size() > 0) ? mq[0] : NOP_PL;
    check("ex_valid", 128'(ex_valid), 128'(mq.size() > 0));
    check("id_ready", 128'(id_ready), 128'(mq.size() < 2));
    check("ex_payload", 128'(obs_pl), 128'(exp_pl));
    if (mq.size() == 0) check("ex_we_bubble", 128'(ex_we), 128'(1'b0));
`ifdef ID_EX_PERF_EN
    check("perf_bubble_cnt", 128'(perf_bubble_cnt), 128'(m_bubbles));
`endif
  endtask

  // One clock: check outputs, apply inputs, advance the model at the edge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic er, input logic [PW-1:0] p);
    int unsigned sz;
    @(negedge clk);
    compare_outputs();
    rst = r; flush = f; id_valid = v; ex_ready = er; id_pl = p;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_bubbles = '0;
    end else begin
      if (er && mq.size() == 0 && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
      if (f) begin
        mq.delete();
      end else begin
        sz = mq.size();
        if (er && sz > 0) void'(mq.pop_front());
        if (v && sz < 2) mq.push_back(p);
      end
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] r1);
    logic [PW-1:0] p;
    p = {$urandom, $urandom, $urandom};
    p[DATA_W+RADDR_W+1 +: DATA_W] = r1;
    return p;
  endfunction

  initial begin
    // Reset held with valid traffic offered.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hDEAD) | 81'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hBEEF) | 81'd1);
    // Back-to-back stream with ex_ready=1.
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h11));
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h22));
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h33));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    // Backpressure: fill, offer while full, then drain.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hA));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hB));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hC));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    // Flush while full, with a payload offered in the same cycle.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hA));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hB));
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'hC));
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'hD));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    // Idle bubbles, then flush (counter must not clear), then reset.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    // Reset while full and execute ready.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hA));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hB));
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'hE));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 6),
           mk($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    compare_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
